// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display blocks: segment bit
// positions, the hex font and the pin polarity helper.
package display_pkg;

    // Cathode vector, bit0 = a ... bit6 = g, 1 = segment on (logical sense)
    typedef logic [6:0] seg7_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Standard hex font, indexed by nibble value
    localparam seg7_t HEX_FONT [16] = '{
        7'h3F,  // 0 abcdef
        7'h06,  // 1 bc
        7'h5B,  // 2 abdeg
        7'h4F,  // 3 abcdg
        7'h66,  // 4 bcfg
        7'h6D,  // 5 acdfg
        7'h7D,  // 6 acdefg
        7'h07,  // 7 abc
        7'h7F,  // 8 all
        7'h6F,  // 9 abcdfg
        7'h77,  // A abcefg
        7'h7C,  // b cdefg
        7'h39,  // C adef
        7'h5E,  // d bcdeg
        7'h79,  // E adefg
        7'h71   // F aefg
    };

    // Convert a logical "on" bit to the physical pin level
    function automatic logic pin_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment decoder (logical polarity,
// 1 = segment on). Shared by the score displays.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    // Font lookup
    always_comb begin
        seg = HEX_FONT[nibble];
    end

endmodule

// File: rtl/display_scan_mux.sv
// Multiplexed seven-segment scanner for NUM_DIGITS common-anode digits.
// A prescaler divides the clock into digit slots; the first BLANK_CYCLES of
// every slot are dark to stop ghosting. Inputs are sampled once per frame so
// a value never tears across digits. Leading zeros can be blanked.
// Optional feature macro: DISPLAY_SCAN_DIM_EN adds a brightness port and a
// PWM duty gate on the lit condition.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int DIM_BITS     = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_enable,
    input  logic                    lz_suppress,
`ifdef DISPLAY_SCAN_DIM_EN
    input  logic [DIM_BITS-1:0]     brightness,
`endif
    output logic [NUM_DIGITS-1:0]   digit_select,
    output logic [6:0]              segments,
    output logic                    seg_dp,
    output logic                    frame_start
);

    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PCNT_W-1:0] BLANK_END = PCNT_W'(BLANK_CYCLES);
    localparam logic              INACTIVE  = (ACTIVE_LOW != 0);

    // Scan state
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tick;
    logic              wrap;

    // Frame shadow registers
    logic [4*NUM_DIGITS-1:0] val_sh_q, val_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
    logic                    lz_sh_q, lz_sh_d;

`ifdef DISPLAY_SCAN_DIM_EN
    logic [DIM_BITS-1:0] bright_sh_q, bright_sh_d;
    logic [DIM_BITS-1:0] pwm_q, pwm_d;
`endif

    // Current-slot view
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  upper_zero;
    logic [3:0]            cur_nib;
    logic                  cur_en;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] cur_onehot;
    seg7_t                 cur_seg;
    logic                  duty_ok;
    logic                  lit;

    // Output registers
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [6:0]            seg_q, seg_d;
    logic                  sdp_q, sdp_d;
    logic                  fs_q, fs_d;

    // Prescaler and scan index next-state; wrap marks the end of a frame
    always_comb begin
        tick   = (pcnt_q == PCNT_LAST);
        wrap   = tick && (idx_q == IDX_LAST);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        idx_d  = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Scan counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
            idx_q  <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
        end
    end

    // Capture all display inputs together at the frame boundary
    always_comb begin
        val_sh_d = val_sh_q;
        dp_sh_d  = dp_sh_q;
        en_sh_d  = en_sh_q;
        lz_sh_d  = lz_sh_q;
`ifdef DISPLAY_SCAN_DIM_EN
        bright_sh_d = bright_sh_q;
`endif
        if (wrap) begin
            val_sh_d = value;
            dp_sh_d  = dp;
            en_sh_d  = digit_enable;
            lz_sh_d  = lz_suppress;
`ifdef DISPLAY_SCAN_DIM_EN
            bright_sh_d = brightness;
`endif
        end
    end

    // Shadow registers; cleared on reset so the first frame is dark
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            val_sh_q <= '0;
            dp_sh_q  <= '0;
            en_sh_q  <= '0;
            lz_sh_q  <= 1'b0;
        end else begin
            val_sh_q <= val_sh_d;
            dp_sh_q  <= dp_sh_d;
            en_sh_q  <= en_sh_d;
            lz_sh_q  <= lz_sh_d;
        end
    end

`ifdef DISPLAY_SCAN_DIM_EN
    // Free-running PWM counter; all-ones brightness bypasses the compare
    always_comb begin
        pwm_d   = pwm_q + 1'b1;
        duty_ok = (bright_sh_q == '1) || (pwm_q < bright_sh_q);
    end

    // PWM counter and brightness shadow
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_q       <= '0;
            bright_sh_q <= '0;
        end else begin
            pwm_q       <= pwm_d;
            bright_sh_q <= bright_sh_d;
        end
    end
`else
    // Without dimming the display always runs at full duty
    always_comb begin
        duty_ok = (DIM_BITS > 0);
    end
`endif

    // Leading-zero mask: walk from the top digit down while nibbles are zero;
    // digit 0 is never suppressed so an all-zero value still shows "0"
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero  = upper_zero && (val_sh_q[4*i +: 4] == 4'h0);
            lz_blank[i] = lz_sh_q && upper_zero;
        end
    end

    // Select the current digit's attributes; only in-range indices match
    always_comb begin
        cur_nib    = 4'h0;
        cur_en     = 1'b0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib       = val_sh_q[4*i +: 4];
                cur_en        = en_sh_q[i];
                cur_dp        = dp_sh_q[i];
                cur_blank     = lz_blank[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Lit condition and pin-polarity conversion for the output registers
    always_comb begin
        lit = cur_en && !cur_blank && (pcnt_q >= BLANK_END) && duty_ok;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_d[i] = pin_level(lit && cur_onehot[i], INACTIVE);
        end
        for (int s = 0; s < 7; s++) begin
            seg_d[s] = pin_level(lit && cur_seg[s], INACTIVE);
        end
        sdp_d = pin_level(lit && cur_dp, INACTIVE);
        fs_d  = wrap;
    end

    // Registered pins; reset drives every output to its inactive level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_q <= {NUM_DIGITS{INACTIVE}};
            seg_q <= {7{INACTIVE}};
            sdp_q <= INACTIVE;
            fs_q  <= 1'b0;
        end else begin
            sel_q <= sel_d;
            seg_q <= seg_d;
            sdp_q <= sdp_d;
            fs_q  <= fs_d;
        end
    end

    assign digit_select = sel_q;
    assign segments     = seg_q;
    assign seg_dp       = sdp_q;
    assign frame_start  = fs_q;

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Parametrised multiplexed seven-segment scanner. Successor to the fixed 8-digit nibble mux.
- Drives NUM_DIGITS common-anode digits from a packed hex value.
- Includes:
  - programmable scan prescaler
  - per-slot anti-ghost blanking
  - frame-coherent snapshot of inputs
  - leading-zero suppression
  - per-digit enable and decimal points
  - integrated hex-to-segment decode
- Sits between game score/timer logic and the board's anode/cathode pins.

Parameters:
- NUM_DIGITS, 8, digit count, legal range 1..16.
- PRESCALE, 100000, clock cycles per digit slot, must be at least 2.
- BLANK_CYCLES, 2, cycles at the start of each slot with all digits off, must be less than PRESCALE.
- ACTIVE_LOW, 1, 1 means anodes and cathodes are active-low, 0 means active-high.
- DIM_BITS, 4, brightness width; used only with DISPLAY_SCAN_DIM_EN.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i is digit i, digit 0 is rightmost.
- dp  in  NUM_DIGITS  decimal point request per digit.
- digit_enable  in  NUM_DIGITS  1 means the digit may light.
- lz_suppress  in  1  enables leading-zero blanking.
- brightness  in  DIM_BITS  duty level; present only with DISPLAY_SCAN_DIM_EN.
- digit_select  out  NUM_DIGITS  anode drive, one-hot active or all inactive.
- segments  out  7  cathodes; bit0=a … bit6=g.
- seg_dp  out  1  decimal point cathode.
- frame_start  out  1  one-cycle pulse when the scan index wraps to 0.

Behaviour:
- **Reset** (reset_n low, asynchronous):
  - prescale counter = 0, index = 0, all shadow registers = 0.
  - digit_select, segments and seg_dp all inactive (all-ones when ACTIVE_LOW=1).
  - frame_start = 0.
- **Prescaler:**
  - pcnt counts 0..PRESCALE-1 and wraps.
  - tick is asserted when pcnt == PRESCALE-1.
- **Scan index:**
  - On tick, index increments; NUM_DIGITS-1 wraps to 0.
  - NUM_DIGITS non-power-of-two is legal and must never select an out-of-range digit.
- **Snapshot:**
  - On the tick that wraps index to 0, capture value, dp, digit_enable and lz_suppress into shadow registers.
  - Assert frame_start on the following cycle, i.e. the first cycle of slot 0.
  - Input changes mid-frame are invisible until the next frame.
  - The first frame after reset shows zeros with all digits disabled; there is no tearing.
- **Leading zero:**
  - Computed from the shadow value.
  - Digit i is blanked when lz_suppress is set and every nibble at position ≥ i is 0.
  - Digit 0 is never blanked by suppression, so value 0 shows "0".
- **Lit condition:** the current digit lights only when all of the following hold:
  - shadow digit_enable[index] is set
  - the digit is not LZ-blanked
  - pcnt ≥ BLANK_CYCLES
- **Outputs:**
  - All outputs are registered; latency is 1 cycle from the pcnt/index state to the pins.
  - When lit: digit_select is active one-hot at index, segments = decode(nibble), seg_dp = shadow dp[index].
  - When not lit: all outputs inactive.
- **Decode:** standard hex font.
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc
  - 8=all, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg
- **Polarity:** ACTIVE_LOW inverts digit_select, segments and seg_dp at the output register.
- **Reset mid-frame:** outputs go inactive immediately (asynchronous). Scanning restarts at slot 0 with pcnt=0 after release.

Optional Feature:
- Macro: DISPLAY_SCAN_DIM_EN.
- **With it:**
  - The brightness port exists.
  - A free-running DIM_BITS-bit PWM counter is added; the lit condition additionally requires pwm < brightness.
  - brightness = all-ones forces full on; brightness = 0 keeps the display dark.
  - brightness is captured into the shadow registers at the frame boundary.
- **Without it:** the port, counter and gating are absent; the display is always at full duty.

Decomposition:
- **Package display_pkg:**
  - SEG_A..SEG_G bit-index constants
  - the 16-entry hex font constant table
  - seg7_t typedef (7-bit)
  - polarity helper function
- **Sub-module seg7_decode:** combinational nibble → seg7_t via the font table. It is reused by other score displays.

Test Plan:
- **Reset and first frame** (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, ACTIVE_LOW=1): hold reset_n=0 for 3 cycles. Required: digit_select=4'b1111, segments=7'h7F. After release, the first frame stays dark and frame_start pulses at cycle 17 after release.
- **Scan order:** value=16'h1234, digit_enable=4'hF, lz_suppress=0. Required per slot:
  - digit_select 1110/1101/1011/0111 with segments ~decode 4,3,2,1
  - one blank cycle at the start of each slot
  - each digit lit for 3 cycles
- **Leading zero:** value=16'h0005, lz_suppress=1. Only digit 0 lights, showing "5". With value=16'h0000, digit 0 shows "0" and digits 1..3 stay dark.
- **Snapshot coherence:** change value from 16'h1111 to 16'h2222 mid-slot 2. The remaining slots still show "1"; the new value appears from the next frame_start.
- **DP and enable:** dp=4'b0100, digit_enable=4'b1011. Required:
  - digit 2 stays dark (disabled), so its dp does not show
  - digit 3 is lit with seg_dp inactive
  - retest with dp=4'b1000: seg_dp is active only during digit 3's lit cycles
- **DISPLAY_SCAN_DIM_EN** (DIM_BITS=2):
  - brightness=2: digit lit only on cycles where pwm is 0 or 1.
  - brightness=0: dark.
  - brightness=3: full lit.
